// File: rtl/yinger_alu_pkg.sv
// rtl/yinger_alu_pkg.sv - ALU codes, funct/op constants and FSM states for the EX unit
package yinger_alu_pkg;

    // Internal 4-bit ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_MFHI = 4'b1100;
    localparam logic [3:0] ALU_MFLO = 4'b1101;
    localparam logic [3:0] ALU_MTHI = 4'b1110;
    localparam logic [3:0] ALU_MTLO = 4'b1111;

    // alu_ct_op classes
    localparam logic [1:0] OP_ITYPE  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;

    // funct field encodings
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } exec_state_e;

    // Ops that run through the iterative engine rather than completing in one cycle
    function automatic logic is_iterative(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_ct_decode.sv
// rtl/alu_ct_decode.sv - combinational alu_ct_op/funct to ALU code, signedness and null flag
module alu_ct_decode
    import yinger_alu_pkg::*;
(
    input  logic [1:0] alu_ct_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_code_o,
    output logic       signed_o,
    output logic       null_o
);

    // Null marks encodings whose architectural result is zero with no side effects
    always_comb begin
        alu_code_o = ALU_AND;
        signed_o   = 1'b0;
        null_o     = 1'b0;
        case (alu_ct_op_i)
            OP_ITYPE: begin
                case (funct_i)
                    FN_ADDU: alu_code_o = ALU_ADD;
                    FN_OR:   alu_code_o = ALU_OR;
                    FN_AND:  alu_code_o = ALU_AND;
                    FN_XOR:  alu_code_o = ALU_XOR;
                    default: alu_code_o = ALU_AND;
                endcase
            end
            OP_BRANCH: alu_code_o = ALU_SUB;
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU:  alu_code_o = ALU_ADD;
                    FN_SUBU:  alu_code_o = ALU_SUB;
                    FN_OR:    alu_code_o = ALU_OR;
                    FN_AND:   alu_code_o = ALU_AND;
                    FN_XOR:   alu_code_o = ALU_XOR;
                    FN_NOR:   alu_code_o = ALU_NOR;
                    FN_SLTU:  alu_code_o = ALU_SLTU;
                    FN_SLT: begin
                        alu_code_o = ALU_SLT;
                        signed_o   = 1'b1;
                    end
                    FN_MULT: begin
                        alu_code_o = ALU_MUL;
                        signed_o   = 1'b1;
                    end
                    FN_MULTU: alu_code_o = ALU_MUL;
                    FN_DIV: begin
                        alu_code_o = ALU_DIV;
                        signed_o   = 1'b1;
                    end
                    FN_DIVU:  alu_code_o = ALU_DIV;
                    FN_MFHI:  alu_code_o = ALU_MFHI;
                    FN_MFLO:  alu_code_o = ALU_MFLO;
                    FN_MTHI:  alu_code_o = ALU_MTHI;
                    FN_MTLO:  alu_code_o = ALU_MTLO;
                    default:  null_o     = 1'b1;
                endcase
            end
            default: null_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with iterative MULT/DIV into HI/LO and valid/ready stall
module alu_exec_unit
    import yinger_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_ct_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_zero,
    output logic             busy
);

    logic [3:0]         dec_code;
    logic               dec_signed;
    logic               dec_null;

    exec_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, result_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q, rem_neg_q, zero_q, div_zero_q;

    logic               accept;
    logic               start_iter;
    logic               div_by_zero;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   alu_res;
    logic               bit_a, bit_b;
    logic [2*WIDTH-1:0] mul_acc, div_acc, acc_d, prod;
    logic [WIDTH:0]     partial, diff;
    logic               q_bit;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    alu_ct_decode u_decode (
        .alu_ct_op_i (alu_ct_op),
        .funct_i     (funct),
        .alu_code_o  (dec_code),
        .signed_o    (dec_signed),
        .null_o      (dec_null)
    );

    // DONE is the result-presentation cycle and may already accept the next op
    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy      = !in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = out_valid & zero_q;
    assign div_zero  = out_valid & div_zero_q;

    assign accept      = in_valid & in_ready;
    assign start_iter  = !dec_null && is_iterative(dec_code);
    assign div_by_zero = (dec_code == ALU_DIV) && (op_b == '0);

    // Magnitudes feed the unsigned engine; signs are re-applied at the end
    assign sign_a = dec_signed & op_a[WIDTH-1];
    assign sign_b = dec_signed & op_b[WIDTH-1];
    assign abs_a  = sign_a ? (~op_a) + WIDTH'(1) : op_a;
    assign abs_b  = sign_b ? (~op_b) + WIDTH'(1) : op_b;

    // Single-cycle result; MTHI/MTLO and unlisted encodings return zero
    always_comb begin
        alu_res = '0;
        case (dec_code)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLTU: alu_res = WIDTH'(op_a < op_b);
            ALU_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
        if (dec_null) begin
            alu_res = '0;
        end
    end

    // One MSB-first iteration: shift-add for MUL, restoring step for DIV (acc = rem:quo)
    always_comb begin
        bit_a   = |(mag_a_q & (WIDTH'(1) << cnt_q));
        bit_b   = |(mag_b_q & (WIDTH'(1) << cnt_q));
        mul_acc = {acc_q[2*WIDTH-2:0], 1'b0}
                + (bit_b ? {{WIDTH{1'b0}}, mag_a_q} : {2*WIDTH{1'b0}});
        partial = {acc_q[2*WIDTH-1:WIDTH], bit_a};
        diff    = partial - {1'b0, mag_b_q};
        q_bit   = !diff[WIDTH];
        div_acc = {(q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], q_bit};
        acc_d   = (state_q == ST_MUL) ? mul_acc : div_acc;
        prod    = neg_q ? (~acc_d) + (2*WIDTH)'(1) : acc_d;
        quo     = neg_q ? (~acc_d[WIDTH-1:0]) + WIDTH'(1) : acc_d[WIDTH-1:0];
        rem     = rem_neg_q ? (~acc_d[2*WIDTH-1:WIDTH]) + WIDTH'(1)
                            : acc_d[2*WIDTH-1:WIDTH];
        fin_hi  = (state_q == ST_MUL) ? prod[2*WIDTH-1:WIDTH] : rem;
        fin_lo  = (state_q == ST_MUL) ? prod[WIDTH-1:0] : quo;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: single-cycle ops and divide-by-zero go straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (start_iter && dec_code == ALU_MUL) begin
                        state_d = ST_MUL;
                    end else if (start_iter && !div_by_zero) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand capture on accept, iteration, HI/LO and result writeback
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            cnt_q      <= CNT_W'(WIDTH - 1);
            acc_q      <= '0;
            mag_a_q    <= abs_a;
            mag_b_q    <= abs_b;
            neg_q      <= sign_a ^ sign_b;
            rem_neg_q  <= sign_a;
            div_zero_q <= 1'b0;
            if (start_iter && div_by_zero) begin
                hi_q       <= op_a;
                lo_q       <= '1;
                result_q   <= '1;
                zero_q     <= 1'b0;
                div_zero_q <= 1'b1;
            end else if (!start_iter) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                if (!dec_null && dec_code == ALU_MTHI) begin
                    hi_q <= op_a;
                end
                if (!dec_null && dec_code == ALU_MTLO) begin
                    lo_q <= op_a;
                end
            end
        end else if (state_q == ST_MUL || state_q == ST_DIV) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                hi_q     <= fin_hi;
                lo_q     <= fin_lo;
                result_q <= fin_lo;
                zero_q   <= (fin_lo == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with directed vectors
module tb_alu_exec_unit;

    localparam logic [1:0] OP_I = 2'b00, OP_BR = 2'b01, OP_R = 2'b10, OP_X = 2'b11;
    localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_OR = 6'b100101,
                           F_AND = 6'b100100, F_XOR = 6'b100110, F_NOR = 6'b100111,
                           F_SLTU = 6'b101011, F_SLT = 6'b101010, F_MULT = 6'b011000,
                           F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011,
                           F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MTHI = 6'b010001,
                           F_MTLO = 6'b010011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_ct_op = '0;
    logic [5:0]  funct = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        div_zero;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        dz;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   n;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ct_op (alu_ct_op),
        .funct     (funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] er, input logic edz);
        exp_t e;
        e.res  = er;
        e.zero = (er == 32'h0) && !edz;
        e.dz   = edz;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input string name, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic edz, input bit push);
        int k = 0;
        while (!in_ready && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL %s_ready: in_ready=0 required 1", name);
        end
        alu_ct_op = op;
        funct     = fn;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        if (push) push_exp(name, er, edz);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle_count(output int cycles);
        cycles = 0;
        while (!in_ready && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Monitor: every out_valid pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (rst && out_valid) begin
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_out_valid: result=%h with empty scoreboard", result);
            end else begin
                mon_e = sb_q.pop_front();
                if (result !== mon_e.res || zero !== mon_e.zero || div_zero !== mon_e.dz) begin
                    mismatched++;
                    $display("FAIL %s: result=%h zero=%b div_zero=%b required result=%h zero=%b div_zero=%b",
                             mon_e.name, result, zero, div_zero, mon_e.res, mon_e.zero, mon_e.dz);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {29'b0, zero, div_zero, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        send("subu", OP_R, F_SUBU, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b1);
        chk("subu_latency", {31'b0, out_valid}, 32'd1);
        send("slt", OP_R, F_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b1);
        send("sltu", OP_R, F_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        send("addu", OP_R, F_ADDU, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);
        send("or", OP_R, F_OR, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1'b1);
        send("and", OP_R, F_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b1);
        send("xor", OP_R, F_XOR, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b1);
        send("nor", OP_R, F_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        send("i_add_wrap", OP_I, F_ADDU, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b1);
        send("i_default_and", OP_I, 6'b000000, 32'h1234, 32'h0FF0, 32'h0230, 1'b0, 1'b1);
        send("branch_sub", OP_BR, F_ADDU, 32'd10, 32'd3, 32'd7, 1'b0, 1'b1);
        send("r_unlisted", OP_R, 6'b111111, 32'd5, 32'd9, 32'h0, 1'b0, 1'b1);
        send("op11", OP_X, F_ADDU, 32'd5, 32'd9, 32'h0, 1'b0, 1'b1);

        send("mult", OP_R, F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, 1'b1);
        wait_idle_count(n);
        chk("mult_busy_cycles", n, 32'd32);
        chk("mult_out_valid", {31'b0, out_valid}, 32'd1);
        send("mfhi_mult", OP_R, F_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        send("mflo_mult", OP_R, F_MFLO, 32'h0, 32'h0, 32'hFFFFFFEB, 1'b0, 1'b1);

        send("div", OP_R, F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b1);
        send("mfhi_div", OP_R, F_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        send("divu_zero", OP_R, F_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
        chk("divu_zero_latency", {30'b0, out_valid, in_ready}, 32'd3);
        @(negedge clk);
        chk("div_zero_idle_low", {30'b0, out_valid, div_zero}, 32'd0);
        send("mfhi_dz", OP_R, F_MFHI, 32'h0, 32'h0, 32'd7, 1'b0, 1'b1);
        send("mflo_dz", OP_R, F_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        send("div_min_m1", OP_R, F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
        send("mfhi_min", OP_R, F_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        send("mthi", OP_R, F_MTHI, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b1);
        send("mtlo", OP_R, F_MTLO, 32'hBEEF, 32'h0, 32'h0, 1'b0, 1'b1);
        send("mfhi_mt", OP_R, F_MFHI, 32'h0, 32'h0, 32'h1234, 1'b0, 1'b1);
        send("mflo_mt", OP_R, F_MFLO, 32'h0, 32'h0, 32'hBEEF, 1'b0, 1'b1);

        // Reset in the middle of MULTU: nothing may come out of it
        send("multu_rst", OP_R, F_MULTU, 32'h12345, 32'h999, 32'h0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {30'b0, in_ready, busy}, 32'd2);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        send("mfhi_after_rst", OP_R, F_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        send("mflo_after_rst", OP_R, F_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // in_valid held high through DIVU; second op only in the out_valid cycle
        alu_ct_op = OP_R;
        funct     = F_DIVU;
        op_a      = 32'd100;
        op_b      = 32'd7;
        in_valid  = 1'b1;
        push_exp("divu_hold_1", 32'd14, 1'b0);
        @(negedge clk);
        wait_idle_count(n);
        chk("divu_hold_busy", n, 32'd32);
        op_a = 32'd9;
        op_b = 32'd3;
        push_exp("divu_hold_2", 32'd3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle_count(n);
        chk("divu_hold2_busy", n, 32'd32);
        send("mfhi_hold", OP_R, F_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
